// File: rtl/capture_sequencer.sv
// +----------------------------------------------------------------------------+
// | capture_sequencer                                                          |
// | Capture-cycle controller: clear / pre-trigger fill / armed / post phases   |
// | for the sample-memory window counter. Optional auto-trigger timeout is     |
// | built when CAPSEQ_AUTO_TRIG_EN is defined.                                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module capture_sequencer #(
    parameter int PRE_W = 18,
    parameter int TMO_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [PRE_W-1:0] i_pre_depth,
    input  logic             i_trig_in,
    input  logic             i_write_ready,
    input  logic [TMO_W-1:0] i_tmo_limit,
    output logic             o_cnt_rst,
    output logic             o_cnt_en_0,
    output logic             o_cnt_en_1,
    output logic             o_trig_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_forced
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_PREFILL = 3'd2;
    localparam logic [2:0] S_ARMED   = 3'd3;
    localparam logic [2:0] S_POST    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [PRE_W-1:0] r_pre_cnt;
    logic             r_forced;
    logic             w_forced_d;
    logic             w_timeout;
    logic             w_cnt_rst;
    logic             w_cnt_en_0;
    logic             w_cnt_en_1;
    logic             w_trig_out;
    logic             w_busy;
    logic             w_done;

`ifdef CAPSEQ_AUTO_TRIG_EN
    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_timeout = (r_state == S_ARMED) && (i_tmo_limit != '0)
                       && (r_tmo_cnt == (i_tmo_limit - TMO_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_ARMED) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    // A real trigger on the timeout cycle wins and leaves FORCED clear.
    always_comb begin
        w_forced_d = r_forced;
        if (i_abort || (w_next_state == S_CLEAR)) begin
            w_forced_d = 1'b0;
        end else if (w_timeout && !i_trig_in) begin
            w_forced_d = 1'b1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_unused_tmo = ^i_tmo_limit;
    assign w_timeout    = 1'b0;
    assign w_forced_d   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_pre_cnt <= '0;
        end else if (r_state == S_PREFILL) begin
            r_pre_cnt <= r_pre_cnt + PRE_W'(1);
        end
    end

    // State register; outputs are registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            o_cnt_rst  <= 1'b0;
            o_cnt_en_0 <= 1'b0;
            o_cnt_en_1 <= 1'b0;
            o_trig_out <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            r_forced   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            o_cnt_rst  <= w_cnt_rst;
            o_cnt_en_0 <= w_cnt_en_0;
            o_cnt_en_1 <= w_cnt_en_1;
            o_trig_out <= w_trig_out;
            o_busy     <= w_busy;
            o_done     <= w_done;
            r_forced   <= w_forced_d;
        end
    end

    assign o_forced = r_forced;

    always_comb begin
        w_next_state = r_state;
        if (i_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (i_start) w_next_state = S_CLEAR;
                S_CLEAR:   w_next_state = (i_pre_depth == '0) ? S_ARMED : S_PREFILL;
                S_PREFILL: if (r_pre_cnt == (i_pre_depth - PRE_W'(1))) w_next_state = S_ARMED;
                S_ARMED:   if (i_trig_in || w_timeout) w_next_state = S_POST;
                S_POST:    if (i_write_ready) w_next_state = S_DONE;
                S_DONE:    if (i_start) w_next_state = S_CLEAR;
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_rst  = 1'b0;
        w_cnt_en_0 = 1'b0;
        w_cnt_en_1 = 1'b0;
        w_trig_out = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (w_next_state)
            S_CLEAR: begin
                w_busy = 1'b1;
            end
            S_PREFILL: begin
                w_cnt_rst  = 1'b1;
                w_cnt_en_0 = 1'b1;
                w_busy     = 1'b1;
            end
            S_ARMED: begin
                w_cnt_rst  = 1'b1;
                w_cnt_en_1 = 1'b1;
                w_busy     = 1'b1;
            end
            S_POST: begin
                w_cnt_rst  = 1'b1;
                w_cnt_en_1 = 1'b1;
                w_trig_out = 1'b1;
                w_busy     = 1'b1;
            end
            S_DONE: begin
                w_cnt_rst = 1'b1;
                w_done    = 1'b1;
            end
            default: begin
                w_cnt_rst = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/capture_sequencer.md
# capture_sequencer

Capture-cycle controller for the sample-memory write path. Sequences the SRAM address/window counter through clear, pre-trigger fill, armed and post-trigger phases, owns the qualified trigger handed to the counter, and reports completion to the MCU interface. It sits between the MCU command registers, the trigger logic and the window counter.

## Interface
- PRE_W, 18, width of the pre-trigger depth count
- TMO_W, 24, width of the auto-trigger timeout count; used only with `CAPSEQ_AUTO_TRIG_EN`
- CLK  in  1  system sample clock
- RST  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle pulse that begins a capture; ignored unless in IDLE or DONE
- ABORT  in  1  one-cycle pulse that returns to IDLE from any state
- PRE_DEPTH  in  PRE_W  number of pre-trigger sample cycles
- TRIG_IN  in  1  trigger event from the trigger logic, level
- WRITE_READY  in  1  window-complete flag from the window counter
- TMO_LIMIT  in  TMO_W  auto-trigger timeout in cycles; 0 disables
- CNT_RST  out  1  active-low clear to the window counter
- CNT_EN_0  out  1  pre-trigger address-count enable
- CNT_EN_1  out  1  armed/post address-count enable
- TRIG_OUT  out  1  qualified trigger to the window counter
- BUSY  out  1  capture in progress
- DONE  out  1  capture complete, level
- FORCED  out  1  last capture ended by timeout, sticky

## Operation
- States: IDLE, CLEAR, PREFILL, ARMED, POST, DONE. The encoding is free.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
- IDLE: CNT_RST=0, enables=0, BUSY=0. START moves to CLEAR.
- CLEAR: lasts exactly 1 cycle. CNT_RST=0, BUSY=1. Loads pre_cnt=0 and tmo_cnt=0.
  - Next state is PREFILL, or ARMED if PRE_DEPTH==0.
- PREFILL: CNT_RST=1, CNT_EN_0=1, BUSY=1.
  - pre_cnt increments each cycle. Leave for ARMED on the cycle pre_cnt==PRE_DEPTH-1, so PREFILL lasts exactly PRE_DEPTH cycles.
  - TRIG_IN is ignored in this state.
- ARMED: CNT_EN_1=1, BUSY=1. TRIG_IN sampled high moves to POST.
- POST: CNT_EN_1=1, TRIG_OUT=1, BUSY=1. WRITE_READY sampled high moves to DONE.
- DONE: enables=0, TRIG_OUT=0, DONE=1, BUSY=0, CNT_RST=1, so the counter keeps its final address for readout.
  - START moves to CLEAR and clears DONE.
- ABORT in any state moves to IDLE on the next edge. ABORT wins over a simultaneous START.
- START outside IDLE/DONE has no effect.
- pre_cnt is PRE_W bits and tmo_cnt is TMO_W bits. Neither wraps: both are compared with equality and reloaded in CLEAR.
- Reset values: state=IDLE, CNT_RST=0, CNT_EN_0=0, CNT_EN_1=0, TRIG_OUT=0, BUSY=0, DONE=0, FORCED=0, pre_cnt=0, tmo_cnt=0.
- Reset asserted mid-capture: all outputs take their reset values immediately and asynchronously.

## Timing
- START sampled at edge n: CNT_RST low from edge n+1, CNT_EN_0 high at edge n+2 (PRE_DEPTH≠0).
- CNT_EN_0 falls and CNT_EN_1 rises on the same edge. The window counter's enable OR sees no gap.
- TRIG_IN high at edge m while ARMED: TRIG_OUT high from edge m+1.
- WRITE_READY high at edge k while in POST: enables low and DONE high at edge k+1.
- ABORT at edge a: BUSY low and CNT_RST low at edge a+1.

## Configuration
- `CAPSEQ_AUTO_TRIG_EN` defined:
  - tmo_cnt increments each ARMED cycle.
  - When tmo_cnt==TMO_LIMIT-1 and TMO_LIMIT≠0, move to POST without TRIG_IN and set FORCED.
  - FORCED clears on the next START or on ABORT.
  - A real TRIG_IN on the same cycle takes precedence and leaves FORCED=0.
- Not defined:
  - TMO_LIMIT is unused and tmo_cnt is not built.
  - FORCED is tied to 0.
  - ARMED waits for TRIG_IN indefinitely.

## Test plan
- Reset, then START with PRE_DEPTH=4, TRIG_IN at the 3rd ARMED cycle, WRITE_READY 10 cycles later:
  - CNT_RST low 1 cycle.
  - CNT_EN_0 high exactly 4 cycles.
  - CNT_EN_1 high until DONE.
  - DONE=1 one cycle after WRITE_READY.
- PRE_DEPTH=0, START: CLEAR goes straight to ARMED and CNT_EN_0 never asserts.
- TRIG_IN held high throughout PREFILL (PRE_DEPTH=8): stays in PREFILL 8 cycles, then POST on the first ARMED sample.
- ABORT during POST, with START on the same cycle: IDLE next cycle, BUSY=0, CNT_RST=0, no restart.
- With `CAPSEQ_AUTO_TRIG_EN`, TMO_LIMIT=5, no TRIG_IN: POST after 5 ARMED cycles with FORCED=1. The next START clears FORCED.
- RST asserted asynchronously mid-PREFILL: all outputs drop to reset values without waiting for a CLK edge, and state returns to IDLE.
